// File: rtl/parser_pkg.sv
// Shared parser metadata definitions: the record layout carried from the parser
// sideband into the metadata queue.
package parser_pkg;

  localparam int META_W = 356;

  typedef struct packed {
    logic [47:0]  dest_mac;
    logic [47:0]  src_mac;
    logic [127:0] src_ip;
    logic [127:0] dest_ip;
    logic [3:0]   version;
  } meta_t;

endpackage

// File: rtl/meta_queue_mem.sv
// Simple dual-port storage for the metadata queue: one write port, one
// registered read port, no reset so it maps onto block RAM.
module meta_queue_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 356,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/meta_queue.sv
// First-word-fall-through queue for parser metadata records with drop counting
// on overflow and an almost-full back-pressure flag.
module meta_queue
  import parser_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [META_W-1:0]       in_meta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [META_W-1:0]       out_meta,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     count_reg, count_next;
  logic [31:0]       drop_reg, drop_next;
  logic              out_valid_reg, out_valid_next;
  logic              pop, push, drop, load;
  logic [META_W-1:0] rd_data;

  // The head record lives in memory at rd_ptr and is mirrored by the read
  // register. A new head is fetched only from entries written before this
  // edge, which keeps the read and write addresses apart whenever both fire.
  always_comb begin
    pop  = out_valid_reg & out_ready;
    push = in_valid & ~flush & ((count_reg != FULL_CNT) | pop);
    drop = in_valid & ~flush & (count_reg == FULL_CNT) & ~pop;
    rd_addr = rd_ptr_reg + AW'(pop);
    load = ~flush & (~out_valid_reg | pop) & ((count_reg - CW'(pop)) != '0);

    wr_ptr_next    = wr_ptr_reg + AW'(push);
    rd_ptr_next    = rd_ptr_reg + AW'(pop);
    count_next     = count_reg + CW'(push) - CW'(pop);
    out_valid_next = (out_valid_reg & ~pop) | load;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      out_valid_next = 1'b0;
    end

    drop_next = drop_reg;
    if (drop && (drop_reg != 32'hFFFF_FFFF)) begin
      drop_next = drop_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      drop_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      drop_reg      <= drop_next;
      out_valid_reg <= out_valid_next;
    end
  end

  meta_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (META_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_meta),
    .rd_en   (load),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The read register has no reset, so the head is masked while nothing is valid.
  assign out_meta    = out_valid_reg ? rd_data : '0;
  assign out_valid   = out_valid_reg;
  assign count       = count_reg;
  assign drop_count  = drop_reg;
  assign almost_full = 32'(count_reg) >= AFULL_LVL;

endmodule
